// File: rtl/dram_bus_responder.sv
// dram_bus_responder
// Target-side emulation of the external DRAM bus. Decodes RAS row opens and
// CAS column strobes (including page-mode bursts), backs every access with an
// on-chip byte array and flags protocol violations with a sticky error bit.
//
// Ports
//   clk                in   bus clock, everything on the rising edge
//   n_rst              in   synchronous reset, active low
//   n_ras_a / n_ras_b  in   row strobes for bank 0 / bank 1
//   n_cas_0 / n_cas_1  in   column strobes for byte lane 0 / lane 1
//   n_nren             in   low marks a non-DRAM cycle (CAS falls ignored)
//   n_we               in   low = write, sampled on the CAS fall
//   addr               in   multiplexed row/column address
//   data_in            in   write data from the bus master
//   data_out           out  registered read data, held while data_oe is low
//   data_oe            out  responder drives the data bus
//   err                out  sticky protocol-error flag
//   rd_count/wr_count  out  saturating completed read / write counters
//
// state     | meaning
// ----------+---------------------------------------------
// IDLE      | no row open
// ROW_OPEN  | bank and row latched, waiting for a CAS fall
// ACCESS    | a CAS is low inside the open row
module dram_bus_responder #(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 6,
   parameter int ADDR_W   = 11
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              n_ras_a,
   input  logic              n_ras_b,
   input  logic              n_cas_0,
   input  logic              n_cas_1,
   input  logic              n_nren,
   input  logic              n_we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        data_in,
   output logic [7:0]        data_out,
   output logic              data_oe,
   output logic              err,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   localparam int IDX_W = ROW_BITS + COL_BITS + 2;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ROW_OPEN = 2'd1;
   localparam logic [1:0] ST_ACCESS   = 2'd2;

   logic [1:0]          state_q, state_d;
   logic                ras_a_prev_q, ras_b_prev_q, cas_0_prev_q, cas_1_prev_q;
   logic                bank_q, bank_d;
   logic [ROW_BITS-1:0] row_q, row_d;
   logic                lane_q, lane_d;
   logic [7:0]          data_out_q, data_out_d;
   logic                data_oe_q, data_oe_d;
   logic                err_q, err_d;
   logic [15:0]         rd_count_q, rd_count_d;
   logic [15:0]         wr_count_q, wr_count_d;

   logic [7:0]          mem [0:(1<<IDX_W)-1];

   logic                ras_a_fall, ras_b_fall, cas_0_fall, cas_1_fall;
   logic                ras_open_n, cas_act_n, cas_other_fall, any_cas_low;
   logic                wr_en, rd_en;
   logic [IDX_W-1:0]    acc_idx;
   logic                addr_unused;

   assign ras_a_fall = !n_ras_a && ras_a_prev_q;
   assign ras_b_fall = !n_ras_b && ras_b_prev_q;
   assign cas_0_fall = !n_cas_0 && cas_0_prev_q;
   assign cas_1_fall = !n_cas_1 && cas_1_prev_q;

   assign ras_open_n     = bank_q ? n_ras_b : n_ras_a;
   assign cas_act_n      = lane_q ? n_cas_1 : n_cas_0;
   assign cas_other_fall = lane_q ? cas_0_fall : cas_1_fall;
   assign any_cas_low    = !n_cas_0 || !n_cas_1;

   // A new access only ever starts with exactly one CAS falling, so the lane
   // is simply "was it cas_1".
   assign acc_idx     = {bank_q, row_q, addr[COL_BITS-1:0], cas_1_fall};
   assign addr_unused = ^addr;

   always_comb begin
      state_d    = state_q;
      bank_d     = bank_q;
      row_d      = row_q;
      lane_d     = lane_q;
      data_out_d = data_out_q;
      data_oe_d  = data_oe_q;
      err_d      = err_q;
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      wr_en      = 1'b0;
      rd_en      = 1'b0;

      if (!n_ras_a && !n_ras_b) begin
         err_d     = 1'b1;
         state_d   = ST_IDLE;
         data_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ras_a_fall || ras_b_fall) begin
                  state_d = ST_ROW_OPEN;
                  row_d   = addr[ROW_BITS-1:0];
                  bank_d  = ras_b_fall;
               end
               if ((cas_0_fall || cas_1_fall) && n_nren)
                  err_d = 1'b1;
            end
            ST_ROW_OPEN: begin
               if (ras_open_n) begin
                  state_d = ST_IDLE;
                  if (any_cas_low) begin
                     err_d     = 1'b1;
                     data_oe_d = 1'b0;
                  end
               end else if (n_nren && cas_0_fall && cas_1_fall) begin
                  err_d = 1'b1;
               end else if (n_nren && (cas_0_fall || cas_1_fall)) begin
                  state_d = ST_ACCESS;
                  lane_d  = cas_1_fall;
                  wr_en   = !n_we;
                  rd_en   = n_we;
               end
            end
            ST_ACCESS: begin
               if (ras_open_n) begin
                  state_d   = ST_IDLE;
                  data_oe_d = 1'b0;
                  if (any_cas_low)
                     err_d = 1'b1;
               end else if (cas_act_n) begin
                  state_d   = ST_ROW_OPEN;
                  data_oe_d = 1'b0;
               end else if (cas_other_fall && n_nren) begin
                  err_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (rd_en) begin
         data_out_d = mem[acc_idx];
         data_oe_d  = 1'b1;
         if (rd_count_q != 16'hFFFF)
            rd_count_d = rd_count_q + 16'd1;
      end
      if (wr_en && wr_count_q != 16'hFFFF)
         wr_count_d = wr_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= ST_IDLE;
         ras_a_prev_q <= 1'b1;
         ras_b_prev_q <= 1'b1;
         cas_0_prev_q <= 1'b1;
         cas_1_prev_q <= 1'b1;
         bank_q       <= 1'b0;
         row_q        <= '0;
         lane_q       <= 1'b0;
         data_out_q   <= 8'h00;
         data_oe_q    <= 1'b0;
         err_q        <= 1'b0;
         rd_count_q   <= 16'h0000;
         wr_count_q   <= 16'h0000;
      end else begin
         state_q      <= state_d;
         ras_a_prev_q <= n_ras_a;
         ras_b_prev_q <= n_ras_b;
         cas_0_prev_q <= n_cas_0;
         cas_1_prev_q <= n_cas_1;
         bank_q       <= bank_d;
         row_q        <= row_d;
         lane_q       <= lane_d;
         data_out_q   <= data_out_d;
         data_oe_q    <= data_oe_d;
         err_q        <= err_d;
         rd_count_q   <= rd_count_d;
         wr_count_q   <= wr_count_d;
      end
   end

   // Array contents survive reset; a write seen together with reset is dropped.
   always_ff @(posedge clk) begin
      if (n_rst && wr_en)
         mem[acc_idx] <= data_in;
   end

   assign data_out = data_out_q;
   assign data_oe  = data_oe_q;
   assign err      = err_q;
   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;

endmodule
